// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : Device-side model of a 4x4 active-high matrix keypad. Accepts
//               key presses on a valid/ready port and plays them out as
//               press bounce, stable hold, release bounce and an inter-key
//               gap. The row return is a purely combinational function of
//               the column drive, like a real switch matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int BOUNCE_CYCLES = 64,
  parameter int BOUNCE_TOGGLE = 8,
  parameter int GAP_CYCLES    = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       pressed,
  output logic       done
);

  // The duration counter only ever holds (length - 1), so it needs
  // clog2 of the longest phase.
  localparam int MAX_HB  = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_CYC = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int TOG_W   = (BOUNCE_TOGGLE > 1) ? $clog2(BOUNCE_TOGGLE) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TOG_W-1:0] TOG_LOAD    = TOG_W'(BOUNCE_TOGGLE - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESS_BOUNCE   = 3'd1,
    HOLD           = 3'd2,
    RELEASE_BOUNCE = 3'd3,
    GAP            = 3'd4
  } state_t;

  state_t           state;
  logic             contact;
  logic [3:0]       key_sel;
  logic [CNT_W-1:0] cnt;
  logic [TOG_W-1:0] tcnt;

  assign key_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign pressed   = contact;

  // Press sequencer: phase durations, contact bounce pattern and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      contact <= 1'b0;
      key_sel <= 4'h0;
      cnt     <= '0;
      tcnt    <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          contact <= 1'b0;
          if (key_valid) begin
            key_sel <= key_code;
            contact <= 1'b1;
            tcnt    <= TOG_LOAD;
            if (BOUNCE_CYCLES > 0) begin
              state <= PRESS_BOUNCE;
              cnt   <= BOUNCE_LOAD;
            end else begin
              state <= HOLD;
              cnt   <= HOLD_LOAD;
            end
          end
        end

        PRESS_BOUNCE: begin
          if (cnt == '0) begin
            state   <= HOLD;
            cnt     <= HOLD_LOAD;
            contact <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            if (tcnt == '0) begin
              contact <= ~contact;
              tcnt    <= TOG_LOAD;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            contact <= 1'b0;
            tcnt    <= TOG_LOAD;
            if (BOUNCE_CYCLES > 0) begin
              state <= RELEASE_BOUNCE;
              cnt   <= BOUNCE_LOAD;
            end else begin
              state <= GAP;
              cnt   <= GAP_LOAD;
              done  <= (GAP_CYCLES == 1);
            end
          end else begin
            contact <= 1'b1;
            cnt     <= cnt - 1'b1;
          end
        end

        RELEASE_BOUNCE: begin
          if (cnt == '0) begin
            state   <= GAP;
            cnt     <= GAP_LOAD;
            contact <= 1'b0;
            done    <= (GAP_CYCLES == 1);
          end else begin
            cnt <= cnt - 1'b1;
            if (tcnt == '0) begin
              contact <= ~contact;
              tcnt    <= TOG_LOAD;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
        end

        GAP: begin
          contact <= 1'b0;
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt  <= cnt - 1'b1;
            // Registered pulse lands in the final GAP cycle (cnt == 0).
            done <= (cnt == CNT_W'(1));
          end
        end

        default: begin
          state   <= IDLE;
          contact <= 1'b0;
        end
      endcase
    end
  end

  // Switch matrix: closed contact shorts the key's column onto its row.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row[r] = contact && (key_sel[3:2] == 2'(r)) && col[key_sel[1:0]];
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench for keypad_emulator. One instance without
//               bounce (timing, row mapping, reset) and one with bounce
//               (contact pattern, busy-ignore, back-to-back accept).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 0: BOUNCE=0, HOLD=10, GAP=4
  logic       key_valid0 = 1'b0;
  logic [3:0] key_code0  = 4'h0;
  logic [3:0] col0       = 4'h0;
  logic       key_ready0, busy0, pressed0, done0;
  logic [3:0] row0;

  // Instance 1: BOUNCE=8, TOGGLE=2, HOLD=4, GAP=2
  logic       key_valid1 = 1'b0;
  logic [3:0] key_code1  = 4'h0;
  logic [3:0] col1       = 4'h0;
  logic       key_ready1, busy1, pressed1, done1;
  logic [3:0] row1;

  keypad_emulator #(
    .HOLD_CYCLES(10), .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .GAP_CYCLES(4)
  ) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid0), .key_code(key_code0),
    .key_ready(key_ready0), .col(col0), .row(row0), .busy(busy0),
    .pressed(pressed0), .done(done0)
  );

  keypad_emulator #(
    .HOLD_CYCLES(4), .BOUNCE_CYCLES(8), .BOUNCE_TOGGLE(2), .GAP_CYCLES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .key_valid(key_valid1), .key_code(key_code1),
    .key_ready(key_ready1), .col(col1), .row(row1), .busy(busy1),
    .pressed(pressed1), .done(done1)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] row;
    logic       done;
    logic       ready;
    logic       pressed;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [3:0] code;
    logic [3:0] col;
    logic [3:0] row;
  } map_t;

  exp_t sb[$];
  exp_t e;
  map_t kmap[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Wait (bounded) until dut0 is idle; leaves us #1 after a posedge.
  task automatic wait_idle0();
    int n = 0;
    while (!key_ready0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle0_timeout", 32'd0, 32'd1);
  endtask

  // Wait (bounded) for a done pulse on dut0, sampled on negedges.
  task automatic wait_done0();
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      seen = done0;
      n++;
    end
    chk("done0_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Single press on dut0; returns #1 after the accept edge (cycle T+1).
  task automatic press0(input logic [3:0] code);
    key_code0  = code;
    key_valid0 = 1'b1;
    @(posedge clk); #1;
    key_valid0 = 1'b0;
  endtask

  localparam logic [3:0] ROT [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  localparam logic [21:0] BOUNCE_PAT = 22'b1100110011110011001100;
  int hits;

  initial begin
    // Key map table: column from key_code[1:0], row from key_code[3:2].
    kmap[0]  = '{4'h0, 4'b0001, 4'b0001}; kmap[1]  = '{4'h1, 4'b0010, 4'b0001};
    kmap[2]  = '{4'h2, 4'b0100, 4'b0001}; kmap[3]  = '{4'h3, 4'b1000, 4'b0001};
    kmap[4]  = '{4'h4, 4'b0001, 4'b0010}; kmap[5]  = '{4'h5, 4'b0010, 4'b0010};
    kmap[6]  = '{4'h6, 4'b0100, 4'b0010}; kmap[7]  = '{4'h7, 4'b1000, 4'b0010};
    kmap[8]  = '{4'h8, 4'b0001, 4'b0100}; kmap[9]  = '{4'h9, 4'b0010, 4'b0100};
    kmap[10] = '{4'hA, 4'b0100, 4'b0100}; kmap[11] = '{4'hB, 4'b1000, 4'b0100};
    kmap[12] = '{4'hC, 4'b0001, 4'b1000}; kmap[13] = '{4'hD, 4'b0010, 4'b1000};
    kmap[14] = '{4'hE, 4'b0100, 4'b1000}; kmap[15] = '{4'hF, 4'b1000, 4'b1000};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_row0", row0, 4'b0000);
    chk("rst_pressed0", pressed0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_ready0", key_ready0, 1'b1);
    chk("rst_done0", done0, 1'b0);
    chk("rst_ready1", key_ready1, 1'b1);

    // ---------------- no-bounce timing, key 5 ----------------
    @(posedge clk); #1;
    col0 = 4'b0010;
    for (int i = 1; i <= 15; i++) begin
      e.row     = (i <= 10) ? 4'b0010 : 4'b0000;
      e.done    = (i == 14);
      e.ready   = (i == 15);
      e.pressed = (i <= 10);
      e.busy    = (i != 15);
      sb.push_back(e);
    end
    press0(4'h5);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("seqA_row[%0d]", i), row0, e.row);
      chk($sformatf("seqA_done[%0d]", i), done0, e.done);
      chk($sformatf("seqA_ready[%0d]", i), key_ready0, e.ready);
    end

    // ---------------- rotating col, key 5 held ----------------
    @(posedge clk); #1;
    wait_idle0();
    press0(4'h5);
    for (int j = 0; j < 8; j++) begin
      col0 = ROT[j % 4];
      #1;
      chk($sformatf("rot_row[%0d]", j), row0, (j % 4 == 1) ? 4'b0010 : 4'b0000);
      @(posedge clk); #1;
    end
    wait_done0();

    // ---------------- full key map ----------------
    for (int k = 0; k < 16; k++) begin
      wait_idle0();
      col0 = kmap[k].col;
      press0(kmap[k].code);
      chk($sformatf("map_row[%0h]", k), row0, kmap[k].row);
      col0 = ~kmap[k].col;
      #1;
      chk($sformatf("map_other_cols[%0h]", k), row0, 4'b0000);
      col0 = 4'b0000;
      #1;
      chk($sformatf("map_col0[%0h]", k), row0, 4'b0000);
      col0 = kmap[k].col;
      wait_done0();
    end

    // ---------------- bounce pattern + busy-ignore (dut1) ----------------
    col1 = 4'b0001;
    for (int i = 1; i <= 24; i++) begin
      if (i <= 22) begin
        e.pressed = BOUNCE_PAT[22 - i];
        e.row     = BOUNCE_PAT[22 - i] ? 4'b0001 : 4'b0000;
        e.busy    = 1'b1;
      end else if (i == 23) begin
        e.pressed = 1'b0; e.row = 4'b0000; e.busy = 1'b0;
      end else begin
        // Key A now latched: column 2 not driven, so no row.
        e.pressed = 1'b1; e.row = 4'b0000; e.busy = 1'b1;
      end
      e.done  = (i == 22);
      e.ready = (i == 23);
      sb.push_back(e);
    end
    key_code1  = 4'h0;
    key_valid1 = 1'b1;
    @(posedge clk); #1;
    key_valid1 = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("bnc_pressed[%0d]", i), pressed1, e.pressed);
      chk($sformatf("bnc_row[%0d]", i), row1, e.row);
      chk($sformatf("bnc_done[%0d]", i), done1, e.done);
      chk($sformatf("bnc_busy[%0d]", i), busy1, e.busy);
      chk($sformatf("bnc_ready[%0d]", i), key_ready1, e.ready);
      if (i == 4) begin
        key_code1  = 4'hA;
        key_valid1 = 1'b1;
      end
    end
    key_valid1 = 1'b0;
    col1 = 4'b0100;
    #1;
    chk("b2b_keyA_row", row1, 4'b0100);

    // ---------------- reset mid-HOLD (dut0) ----------------
    @(posedge clk); #1;
    wait_idle0();
    col0 = 4'b0010;
    press0(4'h5);
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_row0", row0, 4'b0010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_row0", row0, 4'b0000);
    chk("mid_rst_pressed0", pressed0, 1'b0);
    chk("mid_rst_busy0", busy0, 1'b0);
    chk("mid_rst_ready0", key_ready0, 1'b1);
    chk("mid_rst_done0", done0, 1'b0);
    chk("mid_rst_busy1", busy1, 1'b0);
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) hits++;
    end
    chk("post_rst_quiet0", hits, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
